// File: rtl/apb_pkg.sv
// Shared types and constants for the APB RAM completer.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    // Bit positions within apb_pprot
    localparam int PPROT_PRIV  = 0;
    localparam int PPROT_NSEC  = 1;
    localparam int PPROT_INSTR = 2;

    localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/apb_ram_mem.sv
// Byte-strobed single-port RAM with a registered read port, written so it maps onto block RAM.
module apb_ram_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int STRB_W = DATA_W / 8,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] strb,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Read-first behaviour: rdata shows the word as it was before this edge's write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (strb[i]) begin
                    mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/apb_ram_slave.sv
// APB4 completer in front of a byte-strobed RAM, with programmable wait states,
// range/secure-region error responses, error injection and a saturating error counter.
module apb_ram_slave
    import apb_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 16,
    parameter int STRB_W       = DATA_W / 8,
    parameter int DEPTH        = 256,
    parameter int SECURE_WORDS = 16,
    parameter int WAIT_W       = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    apb_paddr,
    input  logic [2:0]           apb_pprot,
    input  logic                 apb_psel,
    input  logic                 apb_penable,
    input  logic                 apb_pwrite,
    input  logic [DATA_W-1:0]    apb_pwdata,
    input  logic [STRB_W-1:0]    apb_pstrb,
    output logic                 apb_pready,
    output logic [DATA_W-1:0]    apb_prdata,
    output logic                 apb_pslverr,
    input  logic [WAIT_W-1:0]    wait_cfg,
    input  logic                 err_inject,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int ADDR_LSB = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int IDX_W    = ADDR_W - ADDR_LSB;
    localparam int MEM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      cnt_q;
    logic                   err_q;
    logic                   pready_q, pslverr_q, rd_valid_q;
    logic [ERR_CNT_W-1:0]   err_cnt_q;
    logic [IDX_W-1:0]       idx;
    logic                   setup, setup_err, err_now, enter_resp, mem_we;
    logic [DATA_W-1:0]      mem_rdata;
    logic                   unused_bits;

    assign idx   = apb_paddr[ADDR_W-1:ADDR_LSB];
    assign setup = apb_psel & ~apb_penable;

    assign setup_err = err_inject
                     | (32'(idx) >= DEPTH)
                     | ((SECURE_WORDS != 0) && (32'(idx) < SECURE_WORDS) && apb_pprot[PPROT_NSEC]);

    assign unused_bits = ^{apb_pprot, apb_paddr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A counter of N spends N cycles in WAIT; leaving on 1 lands pready at T1+N.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d = (wait_cfg != '0) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (!apb_psel) begin
                    state_d = IDLE;
                end else if (cnt_q == WAIT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Zero-wait transfers enter RESP straight from IDLE, so the error must be taken live there.
    always_comb begin
        enter_resp = (state_d == RESP) && (state_q != RESP);
        err_now    = (state_q == IDLE) ? setup_err : err_q;
        mem_we     = enter_resp & apb_pwrite & ~err_now;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            err_q      <= 1'b0;
            pready_q   <= 1'b0;
            pslverr_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            pready_q   <= enter_resp;
            pslverr_q  <= enter_resp & err_now;
            rd_valid_q <= enter_resp & ~apb_pwrite & ~err_now;
            if (state_q == IDLE && setup) begin
                cnt_q <= wait_cfg;
                err_q <= setup_err;
            end else if (state_q == WAIT && apb_psel) begin
                cnt_q <= cnt_q - WAIT_W'(1);
            end
            if (enter_resp && err_now && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
        end
    end

    apb_ram_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .STRB_W (STRB_W),
        .AW     (MEM_AW)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .strb  (apb_pstrb),
        .addr  (idx[MEM_AW-1:0]),
        .wdata (apb_pwdata),
        .rdata (mem_rdata)
    );

    assign apb_pready  = pready_q;
    assign apb_pslverr = pslverr_q;
    assign apb_prdata  = rd_valid_q ? mem_rdata : '0;
    assign err_cnt     = err_cnt_q;

endmodule
